// File: rtl/pc_next_if.sv
// Bus between the instruction decoder/fetch side and the program-counter
// sequencer: control requests in, fetch address and status out.
interface pc_next_if #(
  parameter int PC_W = 10
);
  logic            start;
  logic            halt;
  logic            stall;
  logic            br_rel;
  logic            br_abs;
  logic            taken;
  logic [15:0]     target;
  logic [PC_W-1:0] prog_ctr;
  logic            fetch_valid;
  logic            done;
  logic [15:0]     cycle_cnt;
  logic [7:0]      br_cnt;

  // Controller side: drives requests, observes the sequencer.
  modport master (
    output start, halt, stall, br_rel, br_abs, taken, target,
    input  prog_ctr, fetch_valid, done, cycle_cnt, br_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, halt, stall, br_rel, br_abs, taken, target,
    output prog_ctr, fetch_valid, done, cycle_cnt, br_cnt
  );
endinterface

// File: rtl/pc_next.sv
// Program-counter sequencer. IDLE waits for start, RUN steps the PC
// (halt > stall > taken branch > increment), DONE holds results until
// the next start. Counts RUN cycles and taken branches, both saturating.
module pc_next #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_next_if.slave    bus
);

  localparam logic [PC_W-1:0] START_PC = START_ADDR[PC_W-1:0];
  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cyc_q, cyc_d;
  logic [7:0]      br_q, br_d;
  logic            done_q;

  // Only the low PC_W bits of the target address the PC; the rest is
  // intentionally ignored.
  logic            unused_target;
  assign unused_target = ^bus.target;

  logic [PC_W-1:0] tgt_lo;
  logic [15:0]     cyc_inc;
  logic [7:0]      br_inc;

  assign tgt_lo  = bus.target[PC_W-1:0];
  assign cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
  assign br_inc  = (br_q == 8'hFF) ? br_q : br_q + 8'd1;

  // Next-state and next-PC/counter selection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    br_d    = br_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = START_PC;
          cyc_d   = 16'd0;
          br_d    = 8'd0;
        end
      end
      RUN: begin
        // Every RUN cycle counts, the halt cycle and stalled cycles included.
        cyc_d = cyc_inc;
        if (bus.halt) begin
          state_d = DONE;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.taken && bus.br_abs) begin
          pc_d = tgt_lo;
          br_d = br_inc;
        end else if (bus.taken && bus.br_rel) begin
          // Wraps mod 2^PC_W, so an all-ones target steps back by one.
          pc_d = pc_q + tgt_lo;
          br_d = br_inc;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC, counters and done flag; reset forces the idle state at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      cyc_q   <= 16'd0;
      br_q    <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      br_q    <= br_d;
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.fetch_valid = (state_q == RUN) && !bus.stall;
  assign bus.done        = done_q;
  assign bus.cycle_cnt   = cyc_q;
  assign bus.br_cnt      = br_q;

endmodule

// File: tb/tb_pc_next.sv
// Directed bench for pc_next: a vector table for the main sequencing
// behaviour plus hand-written sequences for async reset and saturation.
module tb_pc_next;

  localparam int PC_W = 10;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  pc_next_if #(.PC_W(PC_W)) bus ();

  pc_next #(.PC_W(PC_W), .START_ADDR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            start;
    logic            halt;
    logic            stall;
    logic            br_rel;
    logic            br_abs;
    logic            taken;
    logic [15:0]     target;
    logic            exp_fv;    // before the edge, with these inputs applied
    logic [PC_W-1:0] exp_pc;    // after the edge
    logic            exp_done;
    logic [15:0]     exp_cyc;
    logic [7:0]      exp_br;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ha, input logic sl, input logic rel,
                       input logic abs_, input logic tk, input logic [15:0] tgt);
    bus.start  = st;
    bus.halt   = ha;
    bus.stall  = sl;
    bus.br_rel = rel;
    bus.br_abs = abs_;
    bus.taken  = tk;
    bus.target = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all(input string tag, input logic [PC_W-1:0] pc, input logic dn,
                           input logic [15:0] cyc, input logic [7:0] br);
    check({tag, ".pc"},   32'(bus.prog_ctr),  32'(pc));
    check({tag, ".done"}, 32'(bus.done),      32'(dn));
    check({tag, ".cyc"},  32'(bus.cycle_cnt), 32'(cyc));
    check({tag, ".br"},   32'(bus.br_cnt),    32'(br));
  endtask

  function automatic vec_t mk(input logic st, input logic ha, input logic sl, input logic rel,
                              input logic abs_, input logic tk, input logic [15:0] tgt,
                              input logic fv, input logic [PC_W-1:0] pc, input logic dn,
                              input logic [15:0] cyc, input logic [7:0] br);
    vec_t v;
    v.start = st; v.halt = ha; v.stall = sl; v.br_rel = rel; v.br_abs = abs_;
    v.taken = tk; v.target = tgt; v.exp_fv = fv; v.exp_pc = pc; v.exp_done = dn;
    v.exp_cyc = cyc; v.exp_br = br;
    return v;
  endfunction

  initial begin
    //            st ha sl rl ab tk target    fv pc       dn cyc      br
    vecs[0]  = mk(0, 1, 0, 0, 1, 1, 16'h0005, 0, 10'h000, 0, 16'd0,  8'd0); // idle ignores all
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, 10'h000, 0, 16'd0,  8'd0); // start
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 10'h001, 0, 16'd1,  8'd0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 10'h002, 0, 16'd2,  8'd0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 10'h003, 0, 16'd3,  8'd0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 10'h004, 0, 16'd4,  8'd0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 10'h005, 0, 16'd5,  8'd0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 1, 16'h0007, 1, 10'h007, 0, 16'd6,  8'd1); // abs jump to 7
    vecs[8]  = mk(0, 0, 0, 1, 0, 1, 16'hFFFF, 1, 10'h006, 0, 16'd7,  8'd2); // rel -1
    vecs[9]  = mk(0, 0, 0, 1, 0, 1, 16'h0003, 1, 10'h009, 0, 16'd8,  8'd3); // rel +3
    vecs[10] = mk(0, 0, 0, 1, 0, 0, 16'h0050, 1, 10'h00A, 0, 16'd9,  8'd3); // not taken
    vecs[11] = mk(0, 0, 0, 1, 1, 1, 16'h03FF, 1, 10'h3FF, 0, 16'd10, 8'd4); // abs beats rel
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 10'h000, 0, 16'd11, 8'd4); // wrap
    vecs[13] = mk(0, 0, 0, 0, 1, 1, 16'h0F03, 1, 10'h303, 0, 16'd12, 8'd5); // upper bits dropped
    vecs[14] = mk(0, 0, 0, 0, 1, 1, 16'h0004, 1, 10'h004, 0, 16'd13, 8'd6);
    vecs[15] = mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 10'h004, 0, 16'd14, 8'd6); // stall
    vecs[16] = mk(0, 0, 1, 0, 1, 1, 16'h0123, 0, 10'h004, 0, 16'd15, 8'd6); // stall beats branch
    vecs[17] = mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 10'h004, 0, 16'd16, 8'd6);
    vecs[18] = mk(1, 0, 0, 0, 0, 0, 16'h0000, 1, 10'h005, 0, 16'd17, 8'd6); // start ignored in RUN
    vecs[19] = mk(0, 1, 1, 0, 1, 1, 16'h0020, 0, 10'h005, 1, 16'd18, 8'd6); // halt beats all
    vecs[20] = mk(0, 0, 0, 0, 1, 1, 16'h0030, 0, 10'h005, 1, 16'd18, 8'd6); // DONE holds
    vecs[21] = mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, 10'h000, 0, 16'd0,  8'd0); // restart
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 10'h001, 0, 16'd1,  8'd0);
    vecs[23] = mk(0, 1, 0, 0, 1, 1, 16'h0099, 1, 10'h001, 1, 16'd2,  8'd0); // halt + abs jump
    vecs[24] = mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, 10'h000, 0, 16'd0,  8'd0); // start from DONE

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 16'h0000);
    #12;
    check("rst.fv", 32'(bus.fetch_valid), 32'd0);
    check_all("rst", 10'h000, 1'b0, 16'd0, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].start, vecs[i].halt, vecs[i].stall, vecs[i].br_rel,
            vecs[i].br_abs, vecs[i].taken, vecs[i].target);
      #1;
      check($sformatf("v%0d.fv", i), 32'(bus.fetch_valid), 32'(vecs[i].exp_fv));
      tick();
      check_all($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_done,
                vecs[i].exp_cyc, vecs[i].exp_br);
    end

    // Run up to PC=12, then pull reset between clock edges.
    drive(0, 0, 0, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 12; i++) tick();
    check_all("pre_arst", 10'd12, 1'b0, 16'd12, 8'd0);
    check("pre_arst.fv", 32'(bus.fetch_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst.fv", 32'(bus.fetch_valid), 32'd0);
    check_all("arst", 10'h000, 1'b0, 16'd0, 8'd0);
    #1 rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle.fv", 32'(bus.fetch_valid), 32'd0);
    check_all("post_rst_idle", 10'h000, 1'b0, 16'd0, 8'd0);
    drive(1, 0, 0, 0, 0, 0, 16'h0000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 16'h0000);
    #1;
    check("post_rst_run.fv", 32'(bus.fetch_valid), 32'd1);
    check_all("post_rst_run", 10'h000, 1'b0, 16'd0, 8'd0);
    tick();
    check_all("post_rst_inc", 10'h001, 1'b0, 16'd1, 8'd0);

    // Branch counter saturation: 300 taken jumps to address 0.
    drive(0, 0, 0, 0, 1, 1, 16'h0000);
    for (int i = 0; i < 300; i++) tick();
    check_all("br_sat", 10'h000, 1'b0, 16'd301, 8'hFF);

    // Cycle counter saturation under a long stall.
    drive(0, 0, 1, 0, 1, 1, 16'h0100);
    for (int i = 0; i < 65540; i++) tick();
    check_all("cyc_sat", 10'h000, 1'b0, 16'hFFFF, 8'hFF);
    drive(0, 1, 0, 0, 0, 0, 16'h0000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 16'h0000);
    #1;
    check("sat_halt.fv", 32'(bus.fetch_valid), 32'd0);
    check_all("sat_halt", 10'h000, 1'b1, 16'hFFFF, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
